// File: rtl/seq_divider.sv
// seq_divider: iterative unsigned restoring divider, one quotient bit per clock.
// Produces quotient/remainder of a WIDTH-bit dividend by a WIDTH-bit divisor.
// Optional feature macro: DIVIDER_DBZ_FAST_EN (divide-by-zero bypasses RUN).
//
// Handshake: start is sampled only while the FSM is in IDLE or DONE; the
// accepting edge captures dividend/divisor. busy is high for the WIDTH cycles
// of RUN; done is a one-cycle pulse in the DONE state, during which
// quotient/remainder/dbz are valid. The results are held until the next
// completion. done and busy are never high together, and start is ignored
// while busy.
module seq_divider #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             dbz,
    output logic [1:0]       dbg_state
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [CW-1:0]    cnt;
    // The partial remainder is always below the divisor between steps, so
    // only WIDTH bits need to be stored; the (WIDTH+1)-bit value exists only
    // transiently as the shifted operand of the trial subtraction.
    logic [WIDTH-1:0] prem;
    logic [WIDTH-1:0] dreg;
    logic [WIDTH-1:0] dsr;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] prem_n;
    logic [WIDTH-1:0] dreg_n;
    logic             accept;
    logic             last_step;
    logic             fast_dbz;

    assign accept    = start && ((state == IDLE) || (state == DONE));
    assign last_step = (state == RUN) && (cnt == CW'(1));

`ifdef DIVIDER_DBZ_FAST_EN
    assign fast_dbz = accept && (divisor == '0);
`else
    assign fast_dbz = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    // Next-state logic: accept in IDLE/DONE, iterate in RUN, DONE lasts one cycle.
    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (accept) state_n = fast_dbz ? DONE : RUN;
            end
            RUN: begin
                if (last_step) state_n = DONE;
            end
            DONE: begin
                if (accept) state_n = fast_dbz ? DONE : RUN;
                else        state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // One restoring step: shift in the next dividend bit, trial-subtract, keep or restore.
    always_comb begin
        shifted = {prem, dreg[WIDTH-1]};
        trial   = shifted - {1'b0, dsr};
        prem_n  = shifted[WIDTH-1:0];
        dreg_n  = {dreg[WIDTH-2:0], 1'b0};
        if (!trial[WIDTH]) begin
            prem_n = trial[WIDTH-1:0];
            dreg_n = {dreg[WIDTH-2:0], 1'b1};
        end
    end

    // Datapath: operand capture, iteration, and result registers updated on completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            prem      <= '0;
            dreg      <= '0;
            dsr       <= '0;
            quotient  <= '0;
            remainder <= '0;
            dbz       <= 1'b0;
        end else if (accept) begin
            dreg <= dividend;
            dsr  <= divisor;
            prem <= '0;
            cnt  <= CW'(WIDTH);
            if (fast_dbz) begin
                cnt       <= '0;
                quotient  <= '1;
                remainder <= dividend;
                dbz       <= 1'b1;
            end
        end else if (state == RUN) begin
            prem <= prem_n;
            dreg <= dreg_n;
            cnt  <= cnt - CW'(1);
            if (last_step) begin
                quotient  <= dreg_n;
                remainder <= prem_n;
                dbz       <= (dsr == '0);
            end
        end
    end

    // Status outputs decoded from the state register.
    always_comb begin
        busy      = (state == RUN);
        done      = (state == DONE);
        dbg_state = state;
    end

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: self-checking bench for seq_divider (WIDTH=4).
// Honours DIVIDER_DBZ_FAST_EN for the divide-by-zero latency expectation.
module tb_seq_divider;

    localparam int W  = 4;
    localparam int EW = 2 * W + 1;
`ifdef DIVIDER_DBZ_FAST_EN
    localparam int LAT_DBZ = 0;
`else
    localparam int LAT_DBZ = W;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         dbz;
    logic [1:0]   dbg_state;

    logic [EW-1:0] exp_q[$];
    int n_cmp = 0;
    int n_err = 0;

    seq_divider #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .dbz       (dbz),
        .dbg_state (dbg_state)
    );

    // Clock.
    always #5 clk = ~clk;

    // Reference model: {quotient, remainder, dbz}.
    function automatic logic [EW-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
        if (b == '0) return {{W{1'b1}}, a, 1'b1};
        return {W'(a / b), W'(a % b), 1'b0};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_start(input logic [W-1:0] a, input logic [W-1:0] b);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        exp_q.push_back(model(a, b));
        tick();
        start = 1'b0;
    endtask

    // Advance until done is seen or the budget runs out; cyc = cycles waited.
    task automatic wait_done(input int budget, output int cyc, output logic got);
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < budget) begin
            if (done) got = 1'b1;
            else begin
                tick();
                cyc++;
            end
        end
    endtask

    // Scoreboard: pop and compare on every done pulse; also watch busy/done overlap.
    always @(negedge clk) begin
        logic [EW-1:0] exp;
        if (rst_n) begin
            n_cmp++;
            if (done && busy) begin
                n_err++;
                $display("FAIL busy_done_overlap: busy=%0b done=%0b, required not both 1", busy, done);
            end
            if (done) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_done: done=1 with no operation outstanding");
                end else begin
                    exp = exp_q.pop_front();
                    if ({quotient, remainder, dbz} !== exp) begin
                        n_err++;
                        $display("FAIL result: got q=%0d r=%0d dbz=%0b, required q=%0d r=%0d dbz=%0b",
                                 quotient, remainder, dbz, exp[EW-1:W+1], exp[W:1], exp[0]);
                    end
                end
            end
        end
    end

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({busy, done, quotient, remainder, dbz, dbg_state} !== '0) begin
            n_err++;
            $display("FAIL reset_values: busy=%0b done=%0b q=%0d r=%0d dbz=%0b st=%0d, required all 0",
                     busy, done, quotient, remainder, dbz, dbg_state);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        drive_start(4'd13, 4'd3);
        for (int i = 0; i < W; i++) begin
            n_cmp++;
            if (busy !== 1'b1 || done !== 1'b0 || quotient !== 4'd0) begin
                n_err++;
                $display("FAIL basic_busy cycle %0d: busy=%0b done=%0b q=%0d, required busy=1 done=0 q=0",
                         i, busy, done, quotient);
            end
            tick();
        end
        n_cmp++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL basic_done: done=%0b busy=%0b, required done=1 busy=0", done, busy);
        end
        tick();
        n_cmp++;
        if (done !== 1'b0 || dbg_state !== 2'd0 || quotient !== 4'd4 || remainder !== 4'd1) begin
            n_err++;
            $display("FAIL basic_after: done=%0b st=%0d q=%0d r=%0d, required done=0 st=0 q=4 r=1",
                     done, dbg_state, quotient, remainder);
        end
    endtask

    task automatic test_back_to_back();
        int   cyc;
        logic got;
        start    = 1'b1;
        dividend = 4'd7;
        divisor  = 4'd9;
        exp_q.push_back(model(4'd7, 4'd9));
        tick();
        wait_done(20, cyc, got);
        n_cmp++;
        if (!got || cyc != W) begin
            n_err++;
            $display("FAIL b2b_first_latency: got=%0b cycles=%0d, required got=1 cycles=%0d", got, cyc, W);
        end
        dividend = 4'd15;
        divisor  = 4'd1;
        exp_q.push_back(model(4'd15, 4'd1));
        tick();
        start = 1'b0;
        wait_done(20, cyc, got);
        n_cmp++;
        if (!got || cyc + 1 != W + 1) begin
            n_err++;
            $display("FAIL b2b_spacing: got=%0b spacing=%0d, required got=1 spacing=%0d", got, cyc + 1, W + 1);
        end
    endtask

    task automatic test_dbz();
        int   cyc;
        logic got;
        drive_start(4'd10, 4'd0);
        wait_done(20, cyc, got);
        n_cmp++;
        if (!got || cyc != LAT_DBZ) begin
            n_err++;
            $display("FAIL dbz_latency: got=%0b cycles=%0d, required got=1 cycles=%0d", got, cyc, LAT_DBZ);
        end
        drive_start(4'd12, 4'd4);
        wait_done(20, cyc, got);
        n_cmp++;
        if (!got || cyc != W || dbz !== 1'b0) begin
            n_err++;
            $display("FAIL dbz_cleared: got=%0b cycles=%0d dbz=%0b, required got=1 cycles=%0d dbz=0",
                     got, cyc, dbz, W);
        end
    endtask

    task automatic test_start_while_busy();
        int n_done;
        drive_start(4'd14, 4'd5);
        tick();
        start    = 1'b1;
        dividend = 4'd9;
        divisor  = 4'd2;
        tick();
        start  = 1'b0;
        n_done = 0;
        repeat (10) begin
            if (done) n_done++;
            tick();
        end
        n_cmp++;
        if (n_done != 1 || quotient !== 4'd2 || remainder !== 4'd4) begin
            n_err++;
            $display("FAIL start_while_busy: pulses=%0d q=%0d r=%0d, required pulses=1 q=2 r=4",
                     n_done, quotient, remainder);
        end
    endtask

    task automatic test_reset_mid_op();
        int   cyc;
        int   n_done;
        logic got;
        drive_start(4'd11, 4'd2);
        tick();
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({busy, done, quotient, remainder, dbz, dbg_state} !== '0) begin
            n_err++;
            $display("FAIL reset_mid_op: busy=%0b done=%0b q=%0d r=%0d dbz=%0b st=%0d, required all 0",
                     busy, done, quotient, remainder, dbz, dbg_state);
        end
        exp_q.delete();
        tick();
        rst_n  = 1'b1;
        n_done = 0;
        repeat (8) begin
            if (done) n_done++;
            tick();
        end
        n_cmp++;
        if (n_done != 0) begin
            n_err++;
            $display("FAIL reset_no_done: pulses=%0d, required 0", n_done);
        end
        drive_start(4'd11, 4'd2);
        wait_done(20, cyc, got);
        n_cmp++;
        if (!got || cyc != W || quotient !== 4'd5 || remainder !== 4'd1) begin
            n_err++;
            $display("FAIL reset_recover: got=%0b cycles=%0d q=%0d r=%0d, required got=1 cycles=%0d q=5 r=1",
                     got, cyc, quotient, remainder, W);
        end
    endtask

    task automatic test_exhaustive();
        int   cyc;
        logic got;
        for (int a = 0; a < (1 << W); a++) begin
            for (int b = 1; b < (1 << W); b++) begin
                drive_start(W'(a), W'(b));
                wait_done(20, cyc, got);
                n_cmp++;
                if (!got || int'(quotient) * b + int'(remainder) != a || int'(remainder) >= b) begin
                    n_err++;
                    $display("FAIL exhaustive %0d/%0d: got=%0b q=%0d r=%0d, required q*d+r=%0d and r<%0d",
                             a, b, got, quotient, remainder, a, b);
                end
            end
        end
        tick();
    endtask

    task automatic test_random();
        int           cyc;
        logic         got;
        logic [W-1:0] a;
        logic [W-1:0] b;
        repeat (24) begin
            a = W'($urandom_range(0, (1 << W) - 1));
            b = ($urandom_range(0, 3) == 0) ? '0 : W'($urandom_range(1, (1 << W) - 1));
            drive_start(a, b);
            wait_done(20, cyc, got);
            n_cmp++;
            if (!got || cyc != ((b == '0) ? LAT_DBZ : W)) begin
                n_err++;
                $display("FAIL random_latency %0d/%0d: got=%0b cycles=%0d, required got=1 cycles=%0d",
                         a, b, got, cyc, (b == '0) ? LAT_DBZ : W);
            end
            if ($urandom_range(0, 1) == 1) tick();
        end
        repeat (2) tick();
    endtask

    // Sequencer and final report.
    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        tick();
        test_dbz();
        tick();
        test_start_while_busy();
        test_reset_mid_op();
        tick();
        test_exhaustive();
        test_random();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL outstanding: %0d results never produced, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Watchdog.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1, "watchdog expired");
    end

endmodule
